// File: rtl/posit16_pkg.sv
// posit16_pkg: shared widths, special encodings and decoded-word layout for posit<16,0> decoding
package posit16_pkg;
  localparam int N  = 16;
  localparam int ES = 0;
  localparam int KW = $clog2(N) + 1;
  localparam int MW = N - 2;
  localparam int LW = $clog2(N);
  localparam logic [N-1:0] ZERO_WORD = 16'h0000;
  localparam logic [N-1:0] NAR_WORD  = 16'h8000;
  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic                 nar;
    logic signed [KW-1:0] k;
    logic [MW-1:0]        mant;
  } posit_dec_t;
endpackage

// File: rtl/posit_run_len.sv
// posit_run_len: combinational length of the leading run of the top bit of a posit body
module posit_run_len #(
  parameter int W  = 15,
  parameter int LW = $clog2(W + 1)
) (
  input  logic [W-1:0]  body,
  output logic [LW-1:0] len
);
  logic run;
  // walk from the MSB, counting bits until the first one that differs from body[W-1]
  always_comb begin
    len = '0;
    run = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      run = run & (body[i] == body[W-1]);
      len = len + LW'(run);
    end
  end
endmodule

// File: rtl/p160_decode_pipe.sv
// p160_decode_pipe: two-stage valid/ready posit<16,0> decoder; P160_DEC_SPECIAL_CNT_EN adds a saturating zero/NaR output counter
module p160_decode_pipe
  import posit16_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_p160,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic                 out_zero,
  output logic                 out_nar,
  output logic signed [KW-1:0] out_k,
`ifdef P160_DEC_SPECIAL_CNT_EN
  output logic [15:0]          special_cnt,
`endif
  output logic [MW-1:0]        out_mant
);
  logic s1_valid, s1_sign, s1_zero, s1_nar, s1_acc, s2_acc, special;
  logic [N-2:0] s1_body;
  logic [LW-1:0] m;
  logic [LW:0] sh;
  logic [MW-2:0] frac;
  posit_dec_t dec;
  assign s2_acc = !out_valid || out_ready;
  assign s1_acc = !s1_valid || s2_acc;
  assign in_ready = s1_acc;
  posit_run_len #(.W(N - 1), .LW(LW)) u_run_len (
    .body (s1_body),
    .len  (m)
  );
  // regime/fraction extraction from the stage-1 magnitude body; specials force k and mant to zero
  always_comb begin
    special = s1_zero || s1_nar;
    sh = {1'b0, m} + 1'b1;
    frac = (MW-1)'((s1_body << sh) >> 2);
    dec.sign = s1_sign;
    dec.zero = s1_zero;
    dec.nar = s1_nar;
    dec.k = special ? '0 : s1_body[N-2] ? KW'(m) - KW'(1) : -KW'(m);
    dec.mant = special ? '0 : {1'b1, frac};
  end
  // stage 1: capture sign, special flags and the low N-1 bits of |p|
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_nar <= 1'b0;
      s1_body <= '0;
    end else begin
      if (s1_acc) s1_valid <= in_valid;
      if (in_valid && s1_acc) begin
        s1_sign <= in_p160[N-1];
        s1_zero <= in_p160 == ZERO_WORD;
        s1_nar <= in_p160 == NAR_WORD;
        s1_body <= in_p160[N-1] ? -in_p160[N-2:0] : in_p160[N-2:0];
      end
    end
  end
  // stage 2: output register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      {out_sign, out_zero, out_nar, out_k, out_mant} <= '0;
    end else begin
      if (s2_acc) out_valid <= s1_valid;
      if (s1_valid && s2_acc) {out_sign, out_zero, out_nar, out_k, out_mant} <= dec;
    end
  end
`ifdef P160_DEC_SPECIAL_CNT_EN
  // count delivered zero/NaR results, saturating at all ones
  always_ff @(posedge clk) begin
    if (rst) special_cnt <= '0;
    else if (out_valid && out_ready && (out_zero || out_nar) && special_cnt != 16'hFFFF) special_cnt <= special_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_p160_decode_pipe.sv
// tb_p160_decode_pipe: directed self-checking bench for p160_decode_pipe (P160_DEC_SPECIAL_CNT_EN optional)
module tb_p160_decode_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_sign, out_zero, out_nar;
  logic [15:0] in_p160;
  logic signed [4:0] out_k;
  logic [13:0] out_mant;
`ifdef P160_DEC_SPECIAL_CNT_EN
  logic [15:0] special_cnt;
`endif
  logic [21:0] got;
  int tests = 0;
  int fails = 0;
  assign got = {out_sign, out_zero, out_nar, out_k, out_mant};
  always #5 clk = ~clk;
  p160_decode_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_p160     (in_p160),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_zero    (out_zero),
    .out_nar     (out_nar),
    .out_k       (out_k),
`ifdef P160_DEC_SPECIAL_CNT_EN
    .special_cnt (special_cnt),
`endif
    .out_mant    (out_mant)
  );
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_p160 = 16'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, got} !== 23'h0) begin
      fails++;
      $display("FAIL reset_state: got %h expected 0", {out_valid, got});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask
  task automatic test_decode();
    logic [15:0] p [10];
    logic [21:0] e [10];
    p[0] = 16'h4000; e[0] = {3'b000, 5'd0, 14'h2000};
    p[1] = 16'h5000; e[1] = {3'b000, 5'd0, 14'h3000};
    p[2] = 16'h6000; e[2] = {3'b000, 5'd1, 14'h2000};
    p[3] = 16'hC000; e[3] = {3'b100, 5'd0, 14'h2000};
    p[4] = 16'h0000; e[4] = {3'b010, 5'd0, 14'h0000};
    p[5] = 16'h8000; e[5] = {3'b101, 5'd0, 14'h0000};
    p[6] = 16'h7FFF; e[6] = {3'b000, 5'd14, 14'h2000};
    p[7] = 16'h0001; e[7] = {3'b000, 5'b10010, 14'h2000};
    p[8] = 16'h4800; e[8] = {3'b000, 5'd0, 14'h2800};
    p[9] = 16'hB000; e[9] = {3'b100, 5'd0, 14'h3000};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_p160 = p[i];
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL early_valid[%h]: out_valid %b expected 0", p[i], out_valid);
      end
      @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b1 || got !== e[i]) begin
        fails++;
        $display("FAIL decode[%h]: valid %b result %h expected valid 1 result %h", p[i], out_valid, got, e[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [15:0] w [4];
    logic [21:0] e [4];
    int idx, n, stall, cyc;
    logic seen, stalling, low_seen;
    w[0] = 16'h4000; e[0] = {3'b000, 5'd0, 14'h2000};
    w[1] = 16'h5000; e[1] = {3'b000, 5'd0, 14'h3000};
    w[2] = 16'h6000; e[2] = {3'b000, 5'd1, 14'h2000};
    w[3] = 16'h7FFF; e[3] = {3'b000, 5'd14, 14'h2000};
    idx = 0; n = 0; stall = 3; cyc = 0;
    seen = 1'b0; low_seen = 1'b0;
    while (n < 4 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid && !seen) seen = 1'b1;
      stalling = seen && stall > 0;
      if (stalling) stall--;
      out_ready = !stalling;
      in_valid = idx < 4;
      in_p160 = idx < 4 ? w[idx] : 16'h0;
      @(negedge clk);
      if (!in_ready) low_seen = 1'b1;
      if (stalling) begin
        tests++;
        if (out_valid !== 1'b1 || got !== e[0]) begin
          fails++;
          $display("FAIL stall_hold: valid %b result %h expected valid 1 result %h", out_valid, got, e[0]);
        end
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        tests++;
        if (got !== e[n]) begin
          fails++;
          $display("FAIL stream[%0d]: result %h expected %h", n, got, e[n]);
        end
        n++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (n != 4 || idx != 4) begin
      fails++;
      $display("FAIL stream_count: sent %0d received %0d expected 4 and 4", idx, n);
    end
    tests++;
    if (low_seen !== 1'b1) begin
      fails++;
      $display("FAIL in_ready_backpressure: in_ready low seen %b expected 1", low_seen);
    end
  endtask
  task automatic test_reset_mid();
    logic stale;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_p160 = 16'h4000;
    @(posedge clk);
    #1;
    in_p160 = 16'h6000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_flush: out_valid %b expected 0", out_valid);
    end
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    tests++;
    if (stale !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_stale: stale output seen %b expected 0", stale);
    end
  endtask
`ifdef P160_DEC_SPECIAL_CNT_EN
  task automatic test_special_cnt();
    logic [15:0] w [3];
    w[0] = 16'h0000;
    w[1] = 16'h4000;
    w[2] = 16'h8000;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_p160 = w[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (special_cnt !== 16'd2) begin
      fails++;
      $display("FAIL special_cnt: got %h expected 0002", special_cnt);
    end
    force dut.special_cnt = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.special_cnt;
    in_valid = 1'b1;
    in_p160 = 16'h0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (special_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL special_cnt_sat: got %h expected ffff", special_cnt);
    end
  endtask
`endif
  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached limit 100000", $time);
    $fatal(1);
  end
  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_reset_mid();
`ifdef P160_DEC_SPECIAL_CNT_EN
    test_special_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
